uart_tx_sb_ctrl: RTL and testbench

- Memory-mapped UART transmitter. Sits on the system bus as a responder to LSU requests, in the same peripheral slot style as the PS/2 and VGA controllers.
- Serialises bytes written by the core onto tx_o: 8N1/8E1/8E2 framing, runtime-programmable bit period.
- Exposes busy and configuration registers for polling.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_tx_sb_ctrl_if.sv | 26 ++
 rtl/uart_tx_core.sv | 152 +++++++++++++++
 rtl/uart_tx_sb_ctrl.sv | 132 +++++++++++++
 tb/tb_uart_tx_sb_ctrl.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// serialiser state encodings and divisor defaults.
package uart_pkg;

    localparam logic [31:0] OFF_DATA      = 32'h0000_0000;
    localparam logic [31:0] OFF_BUSY      = 32'h0000_0004;
    localparam logic [31:0] OFF_DIV       = 32'h0000_0008;
    localparam logic [31:0] OFF_PARITY_EN = 32'h0000_000C;
    localparam logic [31:0] OFF_STOP2     = 32'h0000_0010;
    localparam logic [31:0] OFF_FULL      = 32'h0000_0014;
    localparam logic [31:0] OFF_SOFT_RST  = 32'h0000_0024;

    localparam logic [15:0] UART_DEFAULT_DIV = 16'd1042;
    localparam logic [15:0] UART_MIN_DIV     = 16'd2;

    localparam int unsigned FIFO_DEPTH = 4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        TX_IDLE   = ST_IDLE,
        TX_START  = ST_START,
        TX_DATA   = ST_DATA,
        TX_PARITY = ST_PARITY,
        TX_STOP   = ST_STOP
    } tx_state_t;

endpackage

// File: rtl/uart_tx_sb_ctrl_if.sv
// System-bus responder port of the UART transmitter: LSU request in, registered read data out.
interface uart_tx_sb_ctrl_if;

    logic        req_i;
    logic        write_enable_i;
    logic [31:0] addr_i;
    logic [31:0] write_data_i;
    logic [31:0] read_data_o;

    modport master (
        output req_i,
        output write_enable_i,
        output addr_i,
        output write_data_i,
        input  read_data_o
    );

    modport slave (
        input  req_i,
        input  write_enable_i,
        input  addr_i,
        input  write_data_i,
        output read_data_o
    );

endinterface

// File: rtl/uart_tx_core.sv
// UART serialiser: start bit, 8 data bits LSB first, optional even parity, 1 or 2 stop bits.
// Framing and the byte are latched on start; a start is accepted in IDLE or in the last stop cycle.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter logic [15:0] MIN_DIV = UART_MIN_DIV
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        start,
    input  logic [7:0]  data,
    input  logic [15:0] div,
    input  logic        parity_en,
    input  logic        stop2,
    output logic        tx,
    output logic        busy,
    output logic        last_c
);

    logic [2:0]  state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [15:0] div_q, div_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic        par_en_q, par_en_d;
    logic        stop2_q, stop2_d;
    logic        stop_cnt_q, stop_cnt_d;
    logic        tx_d, busy_d;
    logic        baud_last;
    logic        accept;

    assign baud_last = (baud_q == div_q - 16'd1);
    assign last_c    = (state_q == ST_STOP) & baud_last & (~stop2_q | stop_cnt_q);
    assign accept    = start & ((state_q == ST_IDLE) | last_c);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            div_q      <= MIN_DIV;
            bit_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            par_en_q   <= 1'b0;
            stop2_q    <= 1'b0;
            stop_cnt_q <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            par_en_q   <= par_en_d;
            stop2_q    <= stop2_d;
            stop_cnt_q <= stop_cnt_d;
            tx         <= tx_d;
            busy       <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        div_d      = div_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_d      = par_q;
        par_en_d   = par_en_q;
        stop2_d    = stop2_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx;
        busy_d     = busy;

        if (state_q != ST_IDLE) begin
            baud_d = baud_last ? 16'd0 : baud_q + 16'd1;
        end

        case (state_q)
            ST_IDLE: ;
            ST_START: begin
                if (baud_last) begin
                    state_d = ST_DATA;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    if (bit_q == 3'd7) begin
                        state_d    = par_en_q ? ST_PARITY : ST_STOP;
                        tx_d       = par_en_q ? par_q : 1'b1;
                        stop_cnt_d = 1'b0;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (baud_last) begin
                    state_d    = ST_STOP;
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                end
            end
            ST_STOP: begin
                if (last_c) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (baud_last) begin
                    stop_cnt_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // Back-to-back start overrides the return to IDLE for gap-free frames
        if (accept) begin
            state_d    = ST_START;
            baud_d     = 16'd0;
            div_d      = (div < MIN_DIV) ? MIN_DIV : div;
            bit_d      = 3'd0;
            shift_d    = data;
            par_d      = ^data;
            par_en_d   = parity_en;
            stop2_d    = stop2;
            stop_cnt_d = 1'b0;
            tx_d       = 1'b0;
            busy_d     = 1'b1;
        end

        if (clr) begin
            state_d    = ST_IDLE;
            baud_d     = 16'd0;
            bit_d      = 3'd0;
            stop_cnt_d = 1'b0;
            tx_d       = 1'b1;
            busy_d     = 1'b0;
        end
    end

endmodule

// File: rtl/uart_tx_sb_ctrl.sv
// Memory-mapped UART transmitter on the system bus: register file, read port and serialiser.
// Define UART_TX_FIFO_EN for a 4-entry transmit FIFO and the FULL status register.
module uart_tx_sb_ctrl
    import uart_pkg::*;
#(
    parameter logic [15:0] DEFAULT_DIV = UART_DEFAULT_DIV,
    parameter logic [15:0] MIN_DIV     = UART_MIN_DIV
) (
    input  logic             clk_i,
    input  logic             rst_i,
    uart_tx_sb_ctrl_if.slave bus,
    output logic             tx_o,
    output logic             busy_o
);

    logic        wr, rd;
    logic        data_wr, soft_rst, cfg_we;
    logic [15:0] div_q;
    logic        par_en_q, stop2_q;
    logic        core_start, core_last_c;
    logic [7:0]  core_byte;
    logic [31:0] rdata;
    logic        unused_wdata;

    assign wr           = bus.req_i & bus.write_enable_i;
    assign rd           = bus.req_i & ~bus.write_enable_i;
    assign data_wr      = wr & (bus.addr_i == OFF_DATA);
    assign soft_rst     = wr & (bus.addr_i == OFF_SOFT_RST) & bus.write_data_i[0];
    assign cfg_we       = wr & ~busy_o;
    assign unused_wdata = ^bus.write_data_i[31:16];

    // Framing registers are frozen while a frame (or queued frame) is in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q    <= DEFAULT_DIV;
            par_en_q <= 1'b1;
            stop2_q  <= 1'b0;
        end else if (soft_rst) begin
            div_q    <= DEFAULT_DIV;
            par_en_q <= 1'b1;
            stop2_q  <= 1'b0;
        end else if (cfg_we) begin
            case (bus.addr_i)
                OFF_DIV:       div_q    <= bus.write_data_i[15:0];
                OFF_PARITY_EN: par_en_q <= bus.write_data_i[0];
                OFF_STOP2:     stop2_q  <= bus.write_data_i[0];
                default: ;
            endcase
        end
    end

`ifdef UART_TX_FIFO_EN
    logic [7:0] mem [FIFO_DEPTH];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] cnt;
    logic       full, push, pop;

    // The head entry is the byte on the wire; it leaves when its frame completes
    assign full       = (cnt == 3'(FIFO_DEPTH));
    assign push       = data_wr & ~full & ~soft_rst;
    assign pop        = core_last_c & (cnt != 3'd0);
    assign core_start = ((cnt == 3'd0) & data_wr)
                      | (core_last_c & ((cnt >= 3'd2) | ((cnt == 3'd1) & data_wr)));
    assign core_byte  = (cnt >= 3'd2) ? mem[2'(rd_ptr + 2'd1)] : bus.write_data_i[7:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (soft_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= 2'(wr_ptr + 2'd1);
            if (pop)  rd_ptr <= 2'(rd_ptr + 2'd1);
            cnt <= 3'(cnt + {2'd0, push} - {2'd0, pop});
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= bus.write_data_i[7:0];
    end
`else
    logic unused_last;

    assign unused_last = core_last_c;
    assign core_start  = data_wr & ~busy_o;
    assign core_byte   = bus.write_data_i[7:0];
`endif

    always_comb begin
        rdata = '0;
        case (bus.addr_i)
            OFF_BUSY:      rdata = {31'd0, busy_o};
            OFF_DIV:       rdata = {16'd0, div_q};
            OFF_PARITY_EN: rdata = {31'd0, par_en_q};
            OFF_STOP2:     rdata = {31'd0, stop2_q};
`ifdef UART_TX_FIFO_EN
            OFF_FULL:      rdata = {31'd0, full};
`endif
            default:       rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus.read_data_o <= '0;
        end else if (rd) begin
            bus.read_data_o <= rdata;
        end
    end

    // With the FIFO, a non-empty queue always implies an active frame, so core busy covers both
    uart_tx_core #(
        .MIN_DIV (MIN_DIV)
    ) u_core (
        .clk       (clk_i),
        .rst       (rst_i),
        .clr       (soft_rst),
        .start     (core_start),
        .data      (core_byte),
        .div       (div_q),
        .parity_en (par_en_q),
        .stop2     (stop2_q),
        .tx        (tx_o),
        .busy      (busy_o),
        .last_c    (core_last_c)
    );

endmodule

// File: tb/tb_uart_tx_sb_ctrl.sv
// Directed bench for uart_tx_sb_ctrl: register table, frame waveforms and reset corner cases.
module tb_uart_tx_sb_ctrl;
    import uart_pkg::*;

`ifdef UART_TX_FIFO_EN
    localparam bit FIFO_BUILD = 1'b1;
`else
    localparam bit FIFO_BUILD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx, busy;
    int   checks = 0;
    int   errors = 0;

    uart_tx_sb_ctrl_if bus ();

    uart_tx_sb_ctrl dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus    (bus.slave),
        .tx_o   (tx),
        .busy_o (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [24];

    function automatic vec_t mk(input logic we, input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] e);
        vec_t v;
        v.we = we; v.addr = a; v.wdata = d; v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.req_i = 1'b1; bus.write_enable_i = 1'b1; bus.addr_i = a; bus.write_data_i = d;
        @(negedge clk);
        bus.req_i = 1'b0; bus.write_enable_i = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.req_i = 1'b1; bus.write_enable_i = 1'b0; bus.addr_i = a;
        @(negedge clk);
        bus.req_i = 1'b0;
        d = bus.read_data_o;
    endtask

    // Entered at the first negedge after the frame-start edge; bits[i] is the i-th bit on the wire
    task automatic check_frame(input string name, input logic [15:0] bits, input int nbits,
                               input int eff);
        int bad;
        for (int b = 0; b < nbits; b++) begin
            bad = 0;
            for (int c = 0; c < eff; c++) begin
                if (tx !== bits[b] || busy !== 1'b1) bad++;
                @(negedge clk);
            end
            check($sformatf("%s bit%0d bad cycles", name, b), 32'(bad), 32'd0);
        end
        check({name, " busy after"}, {31'd0, busy}, 32'd0);
        check({name, " tx after"}, {31'd0, tx}, 32'd1);
    endtask

    task automatic check_idle(input string name, input int cycles);
        int bad;
        bad = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check({name, " idle bad cycles"}, 32'(bad), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rv;

        bus.req_i = 1'b0; bus.write_enable_i = 1'b0; bus.addr_i = '0; bus.write_data_i = '0;

        vecs[0]  = mk(1'b0, OFF_BUSY,      32'h0,         32'h0);
        vecs[1]  = mk(1'b0, OFF_DIV,       32'h0,         32'h412);
        vecs[2]  = mk(1'b0, OFF_PARITY_EN, 32'h0,         32'h1);
        vecs[3]  = mk(1'b0, OFF_STOP2,     32'h0,         32'h0);
        vecs[4]  = mk(1'b0, OFF_DATA,      32'h0,         32'h0);
        vecs[5]  = mk(1'b0, OFF_FULL,      32'h0,         32'h0);
        vecs[6]  = mk(1'b0, OFF_SOFT_RST,  32'h0,         32'h0);
        vecs[7]  = mk(1'b0, 32'h18,        32'h0,         32'h0);
        vecs[8]  = mk(1'b1, OFF_DIV,       32'hABCD_1234, 32'h0);
        vecs[9]  = mk(1'b0, OFF_DIV,       32'h0,         32'h1234);
        vecs[10] = mk(1'b1, OFF_PARITY_EN, 32'hFFFF_FFFE, 32'h0);
        vecs[11] = mk(1'b0, OFF_PARITY_EN, 32'h0,         32'h0);
        vecs[12] = mk(1'b1, OFF_STOP2,     32'h3,         32'h0);
        vecs[13] = mk(1'b0, OFF_STOP2,     32'h0,         32'h1);
        vecs[14] = mk(1'b1, 32'h28,        32'h5,         32'h0);
        vecs[15] = mk(1'b0, OFF_DIV,       32'h0,         32'h1234);
        vecs[16] = mk(1'b1, 32'h09,        32'h7777,      32'h0);
        vecs[17] = mk(1'b0, OFF_DIV,       32'h0,         32'h1234);
        vecs[18] = mk(1'b1, OFF_SOFT_RST,  32'h0,         32'h0);
        vecs[19] = mk(1'b0, OFF_DIV,       32'h0,         32'h1234);
        vecs[20] = mk(1'b1, OFF_SOFT_RST,  32'h1,         32'h0);
        vecs[21] = mk(1'b0, OFF_DIV,       32'h0,         32'h412);
        vecs[22] = mk(1'b0, OFF_PARITY_EN, 32'h0,         32'h1);
        vecs[23] = mk(1'b0, OFF_STOP2,     32'h0,         32'h0);

        repeat (3) @(negedge clk);
        check("reset tx", {31'd0, tx}, 32'd1);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset read_data", bus.read_data_o, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 24; i++) begin
            if (vecs[i].we) begin
                bus_write(vecs[i].addr, vecs[i].wdata);
            end else begin
                bus_read(vecs[i].addr, rv);
                check($sformatf("vec%0d read 0x%0h", i, vecs[i].addr), rv, vecs[i].exp);
            end
        end
        check_idle("after table", 5);

        // 0x55, DIV=4, even parity, one stop; bus writes during the frame must not disturb it
        bus_write(OFF_DIV, 32'd4);
        bus_write(OFF_DATA, 32'h55);
        fork
            check_frame("frame55", 16'h04AA, 11, 4);
            begin
                repeat (6) @(negedge clk);
                if (!FIFO_BUILD) bus_write(OFF_DATA, 32'hFF);
                bus_write(OFF_DIV, 32'd8);
            end
        join
        bus_read(OFF_DIV, rv);
        check("div after busy write", rv, 32'd4);
        check_idle("after frame55", 30);

        // 0xA3, DIV=1 clamped to 2, no parity, two stops; DATA write in the final stop cycle ignored
        bus_write(OFF_DIV, 32'd1);
        bus_write(OFF_PARITY_EN, 32'd0);
        bus_write(OFF_STOP2, 32'd1);
        bus_write(OFF_DATA, 32'hA3);
        fork
            check_frame("frameA3", 16'h0746, 11, 2);
            begin
                repeat (20) @(negedge clk);
                if (!FIFO_BUILD) bus_write(OFF_DATA, 32'h00);
            end
        join
        check_idle("after frameA3", 20);

        // Asynchronous reset during data bit 3 of 0x55
        bus_write(OFF_DIV, 32'd4);
        bus_write(OFF_PARITY_EN, 32'd1);
        bus_write(OFF_STOP2, 32'd0);
        bus_write(OFF_DATA, 32'h55);
        repeat (17) @(negedge clk);
        check("pre-reset tx", {31'd0, tx}, 32'd0);
        check("pre-reset busy", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async reset tx", {31'd0, tx}, 32'd1);
        check("async reset busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus_read(OFF_DIV, rv);
        check("div after reset", rv, 32'h412);
        bus_read(OFF_PARITY_EN, rv);
        check("parity after reset", rv, 32'd1);
        check_idle("after async reset", 10);

        // Soft reset mid-frame truncates the frame with no resumption
        bus_write(OFF_DIV, 32'd3);
        bus_write(OFF_DATA, 32'h00);
        repeat (10) @(negedge clk);
        check("pre-soft tx", {31'd0, tx}, 32'd0);
        bus_write(OFF_SOFT_RST, 32'd1);
        check("soft reset tx", {31'd0, tx}, 32'd1);
        check("soft reset busy", {31'd0, busy}, 32'd0);
        bus_read(OFF_DIV, rv);
        check("div after soft reset", rv, 32'h412);
        check_idle("after soft reset", 40);

`ifdef UART_TX_FIFO_EN
        begin
            logic [7:0]  bytes [5];
            logic        samp [90];
            logic        bsy  [90];
            logic [31:0] full_rd;
            logic [9:0]  fr;
            int          bad;
            bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44; bytes[4] = 8'h55;
            full_rd = '0;
            bus_write(OFF_DIV, 32'd2);
            bus_write(OFF_PARITY_EN, 32'd0);
            for (int k = 0; k < 90; k++) begin
                if (k < 5) begin
                    bus.req_i = 1'b1; bus.write_enable_i = 1'b1;
                    bus.addr_i = OFF_DATA; bus.write_data_i = {24'd0, bytes[k]};
                end else if (k == 5) begin
                    bus.req_i = 1'b1; bus.write_enable_i = 1'b0; bus.addr_i = OFF_FULL;
                end else begin
                    bus.req_i = 1'b0; bus.write_enable_i = 1'b0;
                end
                @(negedge clk);
                samp[k] = tx;
                bsy[k]  = busy;
                if (k == 5) full_rd = bus.read_data_o;
            end
            check("fifo full after 4 writes", full_rd, 32'd1);
            for (int f = 0; f < 4; f++) begin
                fr  = {1'b1, bytes[f], 1'b0};
                bad = 0;
                for (int s = 0; s < 20; s++) begin
                    if (samp[f*20 + s] !== fr[s/2] || bsy[f*20 + s] !== 1'b1) bad++;
                end
                check($sformatf("fifo frame%0d bad cycles", f), 32'(bad), 32'd0);
            end
            bad = 0;
            for (int s = 80; s < 90; s++) begin
                if (samp[s] !== 1'b1 || bsy[s] !== 1'b0) bad++;
            end
            check("fifo fifth byte dropped", 32'(bad), 32'd0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
